// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//   Modulo-N up/down counter with clock enable, parallel load and a
//   wrap/saturate mode. The count sequence is 0..i_modulus. A registered
//   one-cycle pulse (o_wrap) marks each wrapping step. A zero-latency carry
//   (o_tc) lets instances be chained: feed o_tc into the next stage's
//   i_clk_en, and that stage steps on the same edge on which this stage wraps.
//
// Parameters
//   WIDTH      counter width in bits (1..16)
//   RESET_VAL  value of o_count after reset and at power-up
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_clk_en    count enable, one step per enabled cycle
//   i_up        1 = increment, 0 = decrement
//   i_sat       0 = wrap at terminal, 1 = hold at terminal
//   i_modulus   terminal (maximum) count
//   i_load      parallel load strobe (takes priority over i_clk_en)
//   i_load_val  load value, clamped to i_modulus
//   o_count     registered count
//   o_wrap      registered pulse, high for the cycle after a wrapping step
//   o_at_term   count is at the terminal for the current direction
//   o_tc        cascade carry: an enabled wrapping step happens this cycle
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int WIDTH     = 3,
  parameter int RESET_VAL = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clk_en,
  input  logic             i_up,
  input  logic             i_sat,
  input  logic [WIDTH-1:0] i_modulus,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap,
  output logic             o_at_term,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];

  // Declaration initialisers give the same state at power-up as after reset.
  logic [WIDTH-1:0] count_q = RST_V;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q  = 1'b0;
  logic             wrap_d;

  logic             up_term;
  logic             dn_term;
  logic             at_term;

  // ">=" rather than "==" so a count stranded above a lowered modulus is
  // treated as terminal and resolved by the next up step.
  assign up_term = (count_q >= i_modulus);
  assign dn_term = (count_q == '0);
  assign at_term = i_up ? up_term : dn_term;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (i_rst) begin
      count_d = RST_V;
    end else if (i_load) begin
      count_d = (i_load_val > i_modulus) ? i_modulus : i_load_val;
    end else if (i_clk_en) begin
      if (i_up) begin
        if (!up_term) begin
          count_d = count_q + WIDTH'(1);
        end else if (!i_sat) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!dn_term) begin
          count_d = count_q - WIDTH'(1);
        end else if (!i_sat) begin
          count_d = i_modulus;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    count_q <= count_d;
    wrap_q  <= wrap_d;
  end

  assign o_count   = count_q;
  assign o_wrap    = wrap_q;
  assign o_at_term = at_term;
  // Same-cycle carry: high exactly when the coming edge performs a wrap.
  assign o_tc      = i_clk_en & at_term & ~i_sat & ~i_load & ~i_rst;

endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       sat;
  logic [2:0] modulus;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] count;
  logic       wrap;
  logic       at_term;
  logic       tc;

  // Cascade pair (WIDTH=4, modulus 9)
  logic       c_en;
  logic [3:0] c_mod;
  logic [3:0] c_zero;
  logic [3:0] c0_count;
  logic [3:0] c1_count;
  logic       c0_wrap;
  logic       c1_wrap;
  logic       c0_at;
  logic       c1_at;
  logic       c0_tc;
  logic       c1_tc;
  logic       c_lo;
  logic       c_hi;

  int checks = 0;
  int errors = 0;

  mod_counter #(.WIDTH(3), .RESET_VAL(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(en), .i_up(up), .i_sat(sat),
    .i_modulus(modulus), .i_load(load), .i_load_val(load_val),
    .o_count(count), .o_wrap(wrap), .o_at_term(at_term), .o_tc(tc)
  );

  mod_counter #(.WIDTH(4), .RESET_VAL(0)) c0 (
    .i_clk(clk), .i_rst(rst), .i_clk_en(c_en), .i_up(c_hi), .i_sat(c_lo),
    .i_modulus(c_mod), .i_load(c_lo), .i_load_val(c_zero),
    .o_count(c0_count), .o_wrap(c0_wrap), .o_at_term(c0_at), .o_tc(c0_tc)
  );

  mod_counter #(.WIDTH(4), .RESET_VAL(0)) c1 (
    .i_clk(clk), .i_rst(rst), .i_clk_en(c0_tc), .i_up(c_hi), .i_sat(c_lo),
    .i_modulus(c_mod), .i_load(c_lo), .i_load_val(c_zero),
    .o_count(c1_count), .o_wrap(c1_wrap), .o_at_term(c1_at), .o_tc(c1_tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int dn_exp [6];
    int n;
    dn_exp = '{2, 1, 0, 5, 4, 3};

    rst = 1'b1; en = 1'b0; up = 1'b1; sat = 1'b0; modulus = 3'd5;
    load = 1'b0; load_val = 3'd0;
    c_en = 1'b0; c_mod = 4'd9; c_zero = 4'd0; c_lo = 1'b0; c_hi = 1'b1;

    // Reset state
    tick();
    chk("rst_count", count, 0);
    chk("rst_wrap", wrap, 0);
    en = 1'b1;
    #1;
    chk("rst_tc_masked", tc, 0);
    chk("rst_c0_count", c0_count, 0);
    chk("rst_c1_count", c1_count, 0);

    // Free-running up count, modulus 5
    rst = 1'b0;
    #1;
    for (int i = 0; i < 12; i++) begin
      chk("up_count", count, i % 6);
      chk("up_wrap", wrap, (i != 0) && (i % 6 == 0));
      chk("up_tc", tc, i % 6 == 5);
      chk("up_at_term", at_term, i % 6 == 5);
      tick();
    end
    chk("up_end_count", count, 0);
    chk("up_end_wrap", wrap, 1);

    // Enable toggling 1,0,1,0...
    load = 1'b1; load_val = 3'd0;
    tick();
    load = 1'b0;
    for (int j = 0; j < 14; j++) begin
      en = (j % 2 == 0);
      #1;
      n = (j + 1) / 2;
      chk("tog_count", count, n % 6);
      chk("tog_wrap", wrap, (j % 2 == 1) && (n % 6 == 0) && (n > 0));
      chk("tog_tc", tc, (j % 2 == 0) && (n % 6 == 5));
      tick();
    end

    // Down count from a load of 2 (load wins over enable)
    load = 1'b1; load_val = 3'd2; en = 1'b1; up = 1'b0;
    tick();
    load = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("dn_count", count, dn_exp[k]);
      chk("dn_wrap", wrap, k == 3);
      chk("dn_tc", tc, dn_exp[k] == 0);
      chk("dn_at_term", at_term, dn_exp[k] == 0);
      tick();
    end

    // Saturate up, modulus 3
    load = 1'b1; load_val = 3'd0;
    tick();
    load = 1'b0; sat = 1'b1; up = 1'b1; modulus = 3'd3;
    #1;
    for (int k = 0; k < 7; k++) begin
      chk("sat_count", count, (k < 3) ? k : 3);
      chk("sat_wrap", wrap, 0);
      chk("sat_tc", tc, 0);
      chk("sat_at_term", at_term, k >= 3);
      tick();
    end

    // Load while at terminal suppresses carry; load clamps to modulus
    sat = 1'b0; load = 1'b1; load_val = 3'd7;
    #1;
    chk("load_at_term", at_term, 1);
    chk("load_tc_masked", tc, 0);
    modulus = 3'd4;
    tick();
    chk("load_clamp_count", count, 4);
    chk("load_clamp_wrap", wrap, 0);
    load = 1'b0;
    #1;
    chk("load_after_tc", tc, 1);

    // Reset beats load
    rst = 1'b1; load = 1'b1;
    #1;
    chk("rst_load_tc", tc, 0);
    tick();
    chk("rst_load_count", count, 0);
    chk("rst_load_wrap", wrap, 0);
    rst = 1'b0; load = 1'b0;

    // Modulus 0: wrap mode pulses, saturate mode stays quiet
    modulus = 3'd0; en = 1'b1; up = 1'b1; sat = 1'b0;
    tick();
    chk("m0_wrap_count", count, 0);
    chk("m0_wrap_pulse", wrap, 1);
    sat = 1'b1;
    tick();
    chk("m0_sat_count", count, 0);
    chk("m0_sat_wrap", wrap, 0);

    // Stale count above a lowered modulus: up step wraps to 0
    sat = 1'b0; modulus = 3'd6; load = 1'b1; load_val = 3'd6;
    tick();
    load = 1'b0; modulus = 3'd2;
    #1;
    chk("stale_tc", tc, 1);
    tick();
    chk("stale_count", count, 0);
    chk("stale_wrap", wrap, 1);

    // Cascade: two decade stages
    en = 1'b0;
    c_en = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      tick();
      chk("cas_lo", c0_count, e % 10);
      chk("cas_hi", c1_count, e / 10);
    end
    c_en = 1'b0;
    tick();
    chk("cas_final_lo", c0_count, 5);
    chk("cas_final_hi", c1_count, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
